life_monitor: RTL and testbench

//  Downstream observer of the game-of-life field register. Samples the SIZE x SIZE field

---
 rtl/life_pkg.sv | 24 ++
 rtl/life_popcount.sv | 30 +++
 rtl/life_monitor.sv | 120 ++++++++++++
 tb/tb_life_monitor.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/life_pkg.sv
// Shared types and helpers for the game-of-life field monitor.
package life_pkg;

    typedef enum logic [1:0] {
        NONE    = 2'd0,
        EXTINCT = 2'd1,
        STILL   = 2'd2,
        OSC2    = 2'd3
    } verdict_t;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RUN     = 2'd1,
        S_SETTLED = 2'd2
    } mon_state_t;

    // Increment that sticks at the all-ones value of a width-bit counter.
    function automatic logic [31:0] sat_inc(input logic [31:0] value, input int unsigned width);
        logic [31:0] max_val;
        max_val = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
        return (value >= max_val) ? max_val : value + 32'd1;
    endfunction

endpackage

// File: rtl/life_popcount.sv
// Combinational population count: pairwise adder tree over a power-of-two padded input.
module life_popcount #(
    parameter int W = 100
) (
    input  logic [W-1:0]             bits,
    output logic [$clog2(W+1)-1:0]   count
);

    localparam int OW = $clog2(W + 1);
    localparam int P  = 1 << $clog2(W);

    logic [P-1:0]  padded;
    logic [OW-1:0] node [P];

    assign padded = P'(bits);

    always_comb begin
        for (int i = 0; i < P; i++) begin
            node[i] = OW'(padded[i]);
        end
        // Each level folds node[i+s] into node[i]; node[0] ends up holding the total.
        for (int s = 1; s < P; s = s * 2) begin
            for (int i = 0; i < P; i = i + 2 * s) begin
                node[i] = node[i] + node[i + s];
            end
        end
        count = node[0];
    end

endmodule

// File: rtl/life_monitor.sv
// Observes the life field each clock: population, generation index, and a latched
// verdict once extinction, still life or a period-2 oscillation repeats CONFIRM times.
module life_monitor
    import life_pkg::*;
#(
    parameter int SIZE    = 10,
    parameter int GEN_W   = 16,
    parameter int CONFIRM = 2
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            load,
    input  logic [SIZE*SIZE-1:0]            field,
    output logic [$clog2(SIZE*SIZE+1)-1:0]  population,
    output logic [GEN_W-1:0]                generation,
    output logic                            gen_sat,
    output logic                            settled,
    output verdict_t                        verdict,
    output mon_state_t                      state
);

    localparam int N     = SIZE * SIZE;
    localparam int POP_W = $clog2(N + 1);
    localparam int CNT_W = $clog2(CONFIRM + 1);

    logic [N-1:0]     prev1;
    logic [N-1:0]     prev2;
    logic [1:0]       hist;
    logic [CNT_W-1:0] match_cnt;
    logic [CNT_W-1:0] match_next;
    verdict_t         prev_class;
    verdict_t         cls;
    mon_state_t       state_next;
    logic [POP_W-1:0] pop_now;
    logic [GEN_W-1:0] gen_next;
    logic             take_verdict;

    life_popcount #(.W(N)) u_popcount (
        .bits  (field),
        .count (pop_now)
    );

    // Classification uses the history as it stood before this sample is absorbed.
    always_comb begin
        cls = NONE;
        if (hist != 2'd0 && pop_now == '0) begin
            cls = EXTINCT;
        end else if (hist != 2'd0 && field == prev1) begin
            cls = STILL;
        end else if (hist == 2'd2 && field == prev2 && field != prev1) begin
            cls = OSC2;
        end

        if (cls == NONE) begin
            match_next = '0;
        end else if (cls == prev_class) begin
            match_next = CNT_W'(sat_inc(32'(match_cnt), CNT_W));
        end else begin
            match_next = CNT_W'(1);
        end

        gen_next = (hist == 2'd0) ? '0 : GEN_W'(sat_inc(32'(generation), GEN_W));
    end

    always_ff @(posedge clk) begin
        if (rst || load) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next   = state;
        take_verdict = 1'b0;
        case (state)
            S_IDLE: state_next = S_RUN;
            S_RUN: begin
                if (int'(match_next) == CONFIRM) begin
                    state_next   = S_SETTLED;
                    take_verdict = 1'b1;
                end
            end
            S_SETTLED: state_next = S_SETTLED;
            default:   state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || load) begin
            population <= rst ? '0 : pop_now;
            generation <= '0;
            gen_sat    <= 1'b0;
            settled    <= 1'b0;
            verdict    <= NONE;
            prev1      <= '0;
            prev2      <= '0;
            hist       <= 2'd0;
            match_cnt  <= '0;
            prev_class <= NONE;
        end else begin
            population <= pop_now;
            prev2      <= prev1;
            prev1      <= field;
            hist       <= (hist == 2'd2) ? 2'd2 : hist + 2'd1;
            generation <= gen_next;
            if (gen_next == '1) begin
                gen_sat <= 1'b1;
            end
            match_cnt  <= match_next;
            prev_class <= cls;
            // Verdict and settled freeze here until the next rst or load.
            if (take_verdict) begin
                verdict <= cls;
                settled <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_life_monitor.sv
// Bench for life_monitor: pattern table, hand sequences and random fields against a queue-based model.
`timescale 1ns/1ps
module tb_life_monitor;
    import life_pkg::*;

    localparam int SIZE    = 10;
    localparam int N       = SIZE * SIZE;
    localparam int POP_W   = 7;
    localparam int CONFIRM = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             load;
    logic [N-1:0]     field;
    logic [POP_W-1:0] population;
    logic [POP_W-1:0] population4;
    logic [15:0]      generation;
    logic [3:0]       generation4;
    logic             gen_sat;
    logic             gen_sat4;
    logic             settled;
    logic             settled4;
    verdict_t         verdict;
    verdict_t         verdict4;
    mon_state_t       state;
    mon_state_t       state4;

    life_monitor #(.SIZE(SIZE), .GEN_W(16), .CONFIRM(CONFIRM)) dut (
        .clk(clk), .rst(rst), .load(load), .field(field),
        .population(population), .generation(generation), .gen_sat(gen_sat),
        .settled(settled), .verdict(verdict), .state(state)
    );

    life_monitor #(.SIZE(SIZE), .GEN_W(4), .CONFIRM(CONFIRM)) dut4 (
        .clk(clk), .rst(rst), .load(load), .field(field),
        .population(population4), .generation(generation4), .gen_sat(gen_sat4),
        .settled(settled4), .verdict(verdict4), .state(state4)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic [POP_W-1:0] pop;
        logic [15:0]      gen;
        logic             gsat;
        logic             set;
        logic [1:0]       ver;
        logic [3:0]       gen4;
        logic             gsat4;
        logic [1:0]       st;
    } exp_t;
    localparam int EXP_W = $bits(exp_t);

    logic [EXP_W-1:0] exp_q[$];
    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [N-1:0] m_fq[$];
    verdict_t     m_cq[$];
    int           m_nsamp = 0;
    bit           m_set   = 1'b0;
    verdict_t     m_ver   = NONE;
    int           m_pop   = 0;

    task automatic model_apply(input bit r, input bit l, input logic [N-1:0] f);
        verdict_t c;
        bit       same;
        if (r || l) begin
            m_fq.delete();
            m_cq.delete();
            m_nsamp = 0;
            m_set   = 1'b0;
            m_ver   = NONE;
            m_pop   = r ? 0 : $countones(f);
        end else begin
            c = NONE;
            if (m_fq.size() >= 1 && $countones(f) == 0) c = EXTINCT;
            else if (m_fq.size() >= 1 && f == m_fq[$]) c = STILL;
            else if (m_fq.size() >= 2 && f == m_fq[$-1] && f != m_fq[$]) c = OSC2;
            m_fq.push_back(f);
            if (m_fq.size() > 2) void'(m_fq.pop_front());
            m_cq.push_back(c);
            if (m_cq.size() > CONFIRM) void'(m_cq.pop_front());
            m_nsamp++;
            m_pop = $countones(f);
            if (!m_set && c != NONE && m_cq.size() == CONFIRM) begin
                same = 1'b1;
                foreach (m_cq[i]) if (m_cq[i] != c) same = 1'b0;
                if (same) begin
                    m_set = 1'b1;
                    m_ver = c;
                end
            end
        end
    endtask

    function automatic exp_t model_snapshot();
        exp_t e;
        int   g;
        g       = (m_nsamp == 0) ? 0 : m_nsamp - 1;
        e.pop   = POP_W'(m_pop);
        e.gen   = (g > 65535) ? 16'hFFFF : 16'(g);
        e.gsat  = (g >= 65535);
        e.set   = m_set;
        e.ver   = m_ver;
        e.gen4  = (g > 15) ? 4'hF : 4'(g);
        e.gsat4 = (g >= 15);
        e.st    = (m_nsamp == 0) ? S_IDLE : (m_set ? S_SETTLED : S_RUN);
        return e;
    endfunction

    // ---------------- stimulus helpers ----------------
    function automatic logic [N-1:0] life_step(input logic [N-1:0] f);
        logic [N-1:0] nf;
        int n, nx, ny;
        nf = '0;
        for (int y = 0; y < SIZE; y++) begin
            for (int x = 0; x < SIZE; x++) begin
                n = 0;
                for (int dy = -1; dy <= 1; dy++) begin
                    for (int dx = -1; dx <= 1; dx++) begin
                        nx = x + dx;
                        ny = y + dy;
                        if ((dx != 0 || dy != 0) && nx >= 0 && nx < SIZE && ny >= 0 && ny < SIZE)
                            if (f[ny*SIZE+nx]) n++;
                    end
                end
                nf[y*SIZE+x] = f[y*SIZE+x] ? (n == 2 || n == 3) : (n == 3);
            end
        end
        return nf;
    endfunction

    function automatic logic [N-1:0] make_pat(input int id);
        logic [N-1:0] f;
        f = '0;
        case (id)
            0: begin f[4*SIZE+4] = 1; f[4*SIZE+5] = 1; f[5*SIZE+4] = 1; f[5*SIZE+5] = 1; end
            1: begin f[4*SIZE+3] = 1; f[4*SIZE+4] = 1; f[4*SIZE+5] = 1; end
            2: f[0] = 1;
            3: begin f[0*SIZE+1] = 1; f[1*SIZE+2] = 1; f[2*SIZE+0] = 1; f[2*SIZE+1] = 1; f[2*SIZE+2] = 1; end
            5: f = '1;
            default: f = '0;
        endcase
        return f;
    endfunction

    function automatic logic [N-1:0] rand_field();
        logic [127:0] a;
        logic [127:0] b;
        a = {$urandom(), $urandom(), $urandom(), $urandom()};
        b = {$urandom(), $urandom(), $urandom(), $urandom()};
        return ($urandom_range(0, 1) == 1) ? a[N-1:0] : (a[N-1:0] & b[N-1:0]);
    endfunction

    // ---------------- driver ----------------
    logic [N-1:0] cur_field;

    task automatic step(input bit r, input bit l, input logic [N-1:0] f);
        exp_t e;
        rst   = r;
        load  = l;
        field = f;
        model_apply(r, l, f);
        exp_q.push_back(model_snapshot());
        @(posedge clk);
        #1;
        e = exp_t'(exp_q.pop_front());
        check("population", int'(population), int'(e.pop));
        check("generation", int'(generation), int'(e.gen));
        check("gen_sat", int'(gen_sat), int'(e.gsat));
        check("settled", int'(settled), int'(e.set));
        check("verdict", int'(verdict), int'(e.ver));
        check("state", int'(state), int'(e.st));
        check("generation4", int'(generation4), int'(e.gen4));
        check("gen_sat4", int'(gen_sat4), int'(e.gsat4));
        check("settled4", int'(settled4), int'(e.set));
    endtask

    task automatic run_pattern(input int pat, input bit hold, input int edges);
        cur_field = make_pat(pat);
        step(1'b0, 1'b1, cur_field);
        for (int k = 0; k < edges; k++) begin
            step(1'b0, 1'b0, cur_field);
            if (!hold) cur_field = life_step(cur_field);
        end
    endtask

    typedef struct {
        int pat;
        bit hold;
        int edges;
        int pop;
        int gen;
        bit set;
        int ver;
    } vec_t;

    vec_t vecs[8];

    initial begin
        logic [N-1:0] last1;
        logic [N-1:0] last2;
        logic [N-1:0] f;
        int           r;

        // pattern, hold, edges, population, generation, settled, verdict
        vecs[0] = '{0, 1'b0, 3,  4,   2, 1'b1, 2};  // block: STILL at edge 3
        vecs[1] = '{0, 1'b0, 2,  4,   1, 1'b0, 0};  // block one edge short
        vecs[2] = '{1, 1'b0, 4,  3,   3, 1'b1, 3};  // blinker: OSC2 at edge 4
        vecs[3] = '{1, 1'b0, 3,  3,   2, 1'b0, 0};  // blinker one edge short
        vecs[4] = '{2, 1'b0, 3,  0,   2, 1'b1, 1};  // single cell dies: EXTINCT
        vecs[5] = '{3, 1'b0, 20, 5,  19, 1'b0, 0};  // glider never settles
        vecs[6] = '{4, 1'b0, 3,  0,   2, 1'b1, 1};  // empty load: EXTINCT after 3
        vecs[7] = '{5, 1'b1, 3,  100, 2, 1'b1, 2};  // full field held constant

        rst   = 1'b1;
        load  = 1'b0;
        field = '0;
        step(1'b1, 1'b0, rand_field());
        step(1'b1, 1'b0, '1);
        check("reset_population", int'(population), 0);
        check("reset_verdict", int'(verdict), 0);

        foreach (vecs[i]) begin
            run_pattern(vecs[i].pat, vecs[i].hold, vecs[i].edges);
            check("tbl_population", int'(population), vecs[i].pop);
            check("tbl_generation", int'(generation), vecs[i].gen);
            check("tbl_settled", int'(settled), int'(vecs[i].set));
            check("tbl_verdict", int'(verdict), vecs[i].ver);
        end

        // Settled blinker, reloaded for one cycle, then re-settles.
        run_pattern(1, 1'b0, 4);
        step(1'b0, 1'b1, make_pat(1));
        check("reload_settled", int'(settled), 0);
        check("reload_verdict", int'(verdict), 0);
        check("reload_generation", int'(generation), 0);
        check("reload_gen_sat", int'(gen_sat), 0);
        cur_field = make_pat(1);
        for (int k = 0; k < 4; k++) begin
            step(1'b0, 1'b0, cur_field);
            cur_field = life_step(cur_field);
        end
        check("resettle_settled", int'(settled), 1);
        check("resettle_verdict", int'(verdict), int'(OSC2));
        check("resettle_generation", int'(generation), 3);

        // Same with rst in place of load; the field keeps evolving.
        step(1'b1, 1'b0, cur_field);
        cur_field = life_step(cur_field);
        check("rst_population", int'(population), 0);
        check("rst_settled", int'(settled), 0);
        check("rst_generation", int'(generation), 0);
        for (int k = 0; k < 4; k++) begin
            step(1'b0, 1'b0, cur_field);
            cur_field = life_step(cur_field);
        end
        check("rst_resettle_settled", int'(settled), 1);
        check("rst_resettle_verdict", int'(verdict), int'(OSC2));

        // Narrow generation counter saturates at 15 on edge 16.
        cur_field = make_pat(3);
        step(1'b0, 1'b1, cur_field);
        for (int k = 1; k <= 18; k++) begin
            step(1'b0, 1'b0, cur_field);
            cur_field = life_step(cur_field);
            if (k == 15) begin
                check("sat4_gen_e15", int'(generation4), 14);
                check("sat4_flag_e15", int'(gen_sat4), 0);
            end
            if (k >= 16) begin
                check("sat4_gen", int'(generation4), 15);
                check("sat4_flag", int'(gen_sat4), 1);
            end
        end
        check("sat16_flag", int'(gen_sat), 0);

        // Random fields with frequent repeats of the last two samples.
        last1 = '0;
        last2 = '0;
        for (int i = 0; i < 700; i++) begin
            r = $urandom_range(0, 99);
            if (r < 2) begin
                step(1'b1, 1'b0, rand_field());
            end else if (r < 6) begin
                f = rand_field();
                step(1'b0, 1'b1, f);
            end else begin
                case ($urandom_range(0, 9))
                    0, 1, 2, 3: f = last1;
                    4, 5:       f = last2;
                    6:          f = '0;
                    7:          f = '1;
                    default:    f = rand_field();
                endcase
                step(1'b0, 1'b0, f);
                last2 = last1;
                last1 = f;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
